// File: rtl/axi_wr_sched.sv
// rtl/axi_wr_sched.sv - multi-outstanding AXI write-channel scheduler with in-order AW->W->B steering
module sel_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int PB = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PB:0]  wr_ptr;
    logic [PB:0]  rd_ptr;

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr[PB-1:0]] <= push_data;
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign head  = mem[rd_ptr[PB-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PB] != rd_ptr[PB]) && (wr_ptr[PB-1:0] == rd_ptr[PB-1:0]);
endmodule

module axi_wr_sched #(
    parameter int SLAVE_NUM       = 2,
    parameter int SEL_BITS        = (SLAVE_NUM > 2) ? $clog2(SLAVE_NUM) : 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TMO_BITS        = 10,
    parameter int OUT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [SLAVE_NUM-1:0] s_awvalid,
    output logic [SLAVE_NUM-1:0] s_awready,
    input  logic [SLAVE_NUM-1:0] s_wvalid,
    input  logic [SLAVE_NUM-1:0] s_wlast,
    output logic [SLAVE_NUM-1:0] s_wready,
    output logic [SLAVE_NUM-1:0] s_bvalid,
    input  logic [SLAVE_NUM-1:0] s_bready,
    output logic                 m_awvalid,
    input  logic                 m_awready,
    output logic                 m_wvalid,
    output logic                 m_wlast,
    input  logic                 m_wready,
    input  logic                 m_bvalid,
    output logic                 m_bready,
    output logic [SEL_BITS-1:0]  aw_sel,
    output logic [SEL_BITS-1:0]  w_sel,
    output logic [SEL_BITS-1:0]  b_sel,
    output logic [OUT_BITS-1:0]  outstanding,
    output logic                 dbg_b_tmo
);
    localparam logic [OUT_BITS-1:0] MAX_OUT  = OUT_BITS'(MAX_OUTSTANDING);
    localparam logic [SEL_BITS-1:0] LAST_IDX = SEL_BITS'(SLAVE_NUM - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_nxt;
    logic [SEL_BITS-1:0] aw_sel_nxt;
    logic [SEL_BITS-1:0] rr_ptr, rr_ptr_nxt;
    logic [SEL_BITS-1:0] pick;
    logic                aw_push;
    logic                w_pop, w_empty, w_full;
    logic                b_pop, b_empty, b_full;
    logic [TMO_BITS-1:0] wdog;

    // Round-robin search: the smallest offset from rr_ptr with a valid request wins
    always_comb begin
        pick = rr_ptr;
        for (int k = SLAVE_NUM - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= SLAVE_NUM) idx = idx - SLAVE_NUM;
            if (s_awvalid[SEL_BITS'(idx)]) pick = SEL_BITS'(idx);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state  <= IDLE;
            aw_sel <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            aw_sel <= aw_sel_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        aw_sel_nxt = aw_sel;
        rr_ptr_nxt = rr_ptr;
        m_awvalid  = 1'b0;
        s_awready  = '0;
        aw_push    = 1'b0;
        case (state)
            IDLE: begin
                if ((|s_awvalid) && (outstanding < MAX_OUT) && !w_full) begin
                    aw_sel_nxt = pick;
                    state_nxt  = GRANT;
                end
            end
            GRANT: begin
                m_awvalid = s_awvalid[aw_sel];
                for (int i = 0; i < SLAVE_NUM; i++) begin
                    s_awready[i] = (SEL_BITS'(i) == aw_sel) && m_awready;
                end
                if (m_awvalid && m_awready) begin
                    aw_push    = 1'b1;
                    rr_ptr_nxt = (aw_sel == LAST_IDX) ? '0 : aw_sel + SEL_BITS'(1);
                    state_nxt  = IDLE;
                end else if (!s_awvalid[aw_sel]) begin
                    // Requester withdrew its address: drop the grant without tracking it
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    sel_fifo #(.W(SEL_BITS), .DEPTH(MAX_OUTSTANDING)) u_w_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (aw_push),
        .push_data (aw_sel),
        .pop       (w_pop),
        .head      (w_sel),
        .empty     (w_empty),
        .full      (w_full)
    );

    sel_fifo #(.W(SEL_BITS), .DEPTH(MAX_OUTSTANDING)) u_b_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .push      (w_pop),
        .push_data (w_sel),
        .pop       (b_pop),
        .head      (b_sel),
        .empty     (b_empty),
        .full      (b_full)
    );

    always_comb begin
        m_wvalid = !w_empty && s_wvalid[w_sel];
        m_wlast  = s_wlast[w_sel];
        m_bready = !b_empty && s_bready[b_sel];
        s_wready = '0;
        s_bvalid = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            s_wready[i] = !w_empty && (SEL_BITS'(i) == w_sel) && m_wready;
            s_bvalid[i] = !b_empty && (SEL_BITS'(i) == b_sel) && m_bvalid;
        end
        w_pop = m_wvalid && m_wready && m_wlast;
        b_pop = m_bvalid && m_bready;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            outstanding <= '0;
            wdog        <= '0;
        end else begin
            case ({aw_push, b_pop})
                2'b10:   outstanding <= outstanding + OUT_BITS'(1);
                2'b01:   outstanding <= outstanding - OUT_BITS'(1);
                default: outstanding <= outstanding;
            endcase
            if ((outstanding == '0) || b_pop) wdog <= '0;
            else if (!(&wdog))                wdog <= wdog + TMO_BITS'(1);
        end
    end

    assign dbg_b_tmo = &wdog;
endmodule

// File: tb/tb_axi_wr_sched.sv
// tb/tb_axi_wr_sched.sv - table vectors plus W/B order scoreboard for axi_wr_sched
module tb_axi_wr_sched;
    logic       aclk = 1'b0;
    logic       areset;
    logic [1:0] s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
    logic       m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic       aw_sel, w_sel, b_sel;
    logic [2:0] outstanding;
    logic       dbg_b_tmo;

    int checks = 0;
    int errors = 0;
    logic [31:0] w_exp[$];
    logic [31:0] b_exp[$];

    typedef struct {
        logic [1:0] awv;
        logic       exp_mav;
        logic       exp_sel;
        logic [1:0] exp_rdy;
        logic [2:0] exp_out;
    } vec_t;
    vec_t tbl[10];

    axi_wr_sched dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wvalid    (s_wvalid),
        .s_wlast     (s_wlast),
        .s_wready    (s_wready),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wvalid    (m_wvalid),
        .m_wlast     (m_wlast),
        .m_wready    (m_wready),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .aw_sel      (aw_sel),
        .w_sel       (w_sel),
        .b_sel       (b_sel),
        .outstanding (outstanding),
        .dbg_b_tmo   (dbg_b_tmo)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        w_exp.delete();
        b_exp.delete();
        tick();
        areset = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        settle();
        chk({tag, "_m_awvalid"}, 32'(m_awvalid), 0);
        chk({tag, "_s_awready"}, 32'(s_awready), 0);
        chk({tag, "_m_wvalid"}, 32'(m_wvalid), 0);
        chk({tag, "_m_wlast"}, 32'(m_wlast), 0);
        chk({tag, "_s_wready"}, 32'(s_wready), 0);
        chk({tag, "_s_bvalid"}, 32'(s_bvalid), 0);
        chk({tag, "_m_bready"}, 32'(m_bready), 0);
        chk({tag, "_aw_sel"}, 32'(aw_sel), 0);
        chk({tag, "_outstanding"}, 32'(outstanding), 0);
        chk({tag, "_dbg_b_tmo"}, 32'(dbg_b_tmo), 0);
    endtask

    // Completed W bursts and B handshakes must follow the order the bench granted them
    always @(negedge aclk) begin
        if (areset === 1'b0) begin
            if (m_wvalid && m_wready && m_wlast) begin
                if (w_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL w_order actual=%0d expected=none", w_sel);
                end else chk("w_order", 32'(w_sel), w_exp.pop_front());
            end
            if (m_bvalid && m_bready) begin
                if (b_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_order actual=%0d expected=none", b_sel);
                end else chk("b_order", 32'(b_sel), b_exp.pop_front());
            end
        end
    end

    initial begin
        //        awv    mav   sel   rdy    out
        tbl[0] = '{2'b11, 1'b0, 1'b0, 2'b00, 3'd0};
        tbl[1] = '{2'b11, 1'b1, 1'b0, 2'b01, 3'd0};
        tbl[2] = '{2'b11, 1'b0, 1'b0, 2'b00, 3'd1};
        tbl[3] = '{2'b11, 1'b1, 1'b1, 2'b10, 3'd1};
        tbl[4] = '{2'b11, 1'b0, 1'b1, 2'b00, 3'd2};
        tbl[5] = '{2'b11, 1'b1, 1'b0, 2'b01, 3'd2};
        tbl[6] = '{2'b11, 1'b0, 1'b0, 2'b00, 3'd3};
        tbl[7] = '{2'b11, 1'b1, 1'b1, 2'b10, 3'd3};
        tbl[8] = '{2'b11, 1'b0, 1'b1, 2'b00, 3'd4};
        tbl[9] = '{2'b11, 1'b0, 1'b1, 2'b00, 3'd4};

        idle_in();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        chk_quiet("reset");

        // Alternating grants with both requesters held, filling to the outstanding limit
        m_awready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_awvalid = tbl[i].awv;
            settle();
            chk($sformatf("rr%0d_m_awvalid", i), 32'(m_awvalid), 32'(tbl[i].exp_mav));
            chk($sformatf("rr%0d_aw_sel", i), 32'(aw_sel), 32'(tbl[i].exp_sel));
            chk($sformatf("rr%0d_s_awready", i), 32'(s_awready), 32'(tbl[i].exp_rdy));
            chk($sformatf("rr%0d_outstanding", i), 32'(outstanding), 32'(tbl[i].exp_out));
            tick();
        end
        idle_in();
        do_reset();

        // Four AWs from requester 1, fifth blocked until a B completes
        s_awvalid = 2'b10; m_awready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) w_exp.push_back(1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lim_blocked_m_awvalid", 32'(m_awvalid), 0);
            chk("lim_outstanding", 32'(outstanding), 4);
            tick();
        end
        s_wvalid = 2'b10; s_wlast = 2'b10; m_wready = 1'b1;
        b_exp.push_back(1);
        settle();
        chk("lim_s_wready", 32'(s_wready), 2);
        tick();
        s_wvalid = '0; s_wlast = '0;
        m_bvalid = 1'b1; s_bready = 2'b10;
        settle();
        chk("lim_m_bready", 32'(m_bready), 1);
        chk("lim_b_m_awvalid", 32'(m_awvalid), 0);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        settle();
        chk("lim_idle_m_awvalid", 32'(m_awvalid), 0);
        chk("lim_out_after_b", 32'(outstanding), 3);
        tick();
        settle();
        chk("lim_regrant_m_awvalid", 32'(m_awvalid), 1);
        chk("lim_regrant_aw_sel", 32'(aw_sel), 1);
        w_exp.push_back(1);
        tick();
        settle();
        chk("lim_out_refill", 32'(outstanding), 4);
        idle_in();
        do_reset();
        chk_quiet("reset2");

        // W ordering: bursts of 3 beats (req 0) then 1 beat (req 1), req 1 data presented early
        s_awvalid = 2'b11; m_awready = 1'b1; s_wvalid = 2'b10; m_wready = 1'b1;
        w_exp.push_back(0); w_exp.push_back(1);
        settle();
        chk("w_early_m_wvalid", 32'(m_wvalid), 0);
        chk("w_early_s_wready", 32'(s_wready), 0);
        tick();
        settle();
        chk("w_early2_s_wready", 32'(s_wready), 0);
        tick();
        settle();
        chk("w_stall_m_wvalid", 32'(m_wvalid), 0);
        chk("w_stall_s_wready", 32'(s_wready), 1);
        tick();
        tick();
        s_awvalid = '0; s_wvalid = 2'b11;
        for (int b = 0; b < 3; b++) begin
            s_wlast = (b == 2) ? 2'b01 : 2'b00;
            if (b == 2) b_exp.push_back(0);
            settle();
            chk($sformatf("w0_beat%0d_w_sel", b), 32'(w_sel), 0);
            chk($sformatf("w0_beat%0d_m_wvalid", b), 32'(m_wvalid), 1);
            chk($sformatf("w0_beat%0d_s_wready", b), 32'(s_wready), 1);
            chk($sformatf("w0_beat%0d_m_wlast", b), 32'(m_wlast), (b == 2) ? 1 : 0);
            tick();
        end
        s_wlast = 2'b10;
        b_exp.push_back(1);
        settle();
        chk("w1_w_sel", 32'(w_sel), 1);
        chk("w1_s_wready", 32'(s_wready), 2);
        chk("w1_m_wlast", 32'(m_wlast), 1);
        tick();
        s_wvalid = '0; s_wlast = '0;
        settle();
        chk("w_done_outstanding", 32'(outstanding), 2);

        // B backpressure from requester 0 holds the response at the FIFO head
        m_bvalid = 1'b1; s_bready = 2'b00;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bhold_b_sel", 32'(b_sel), 0);
            chk("bhold_m_bready", 32'(m_bready), 0);
            chk("bhold_s_bvalid", 32'(s_bvalid), 1);
            tick();
        end
        s_bready = 2'b01;
        settle();
        chk("b0_m_bready", 32'(m_bready), 1);
        tick();
        settle();
        chk("b1_b_sel", 32'(b_sel), 1);
        chk("b1_s_bvalid", 32'(s_bvalid), 2);
        chk("b1_m_bready_blocked", 32'(m_bready), 0);
        s_bready = 2'b10;
        settle();
        chk("b1_m_bready", 32'(m_bready), 1);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        settle();
        chk("b_done_outstanding", 32'(outstanding), 0);

        // Same-cycle AW and B handshakes at outstanding=2
        s_awvalid = 2'b11;
        w_exp.push_back(0); w_exp.push_back(1);
        for (int i = 0; i < 4; i++) tick();
        s_awvalid = '0;
        s_wvalid = 2'b01; s_wlast = 2'b01; b_exp.push_back(0);
        tick();
        s_wvalid = 2'b10; s_wlast = 2'b10; b_exp.push_back(1);
        tick();
        s_wvalid = '0; s_wlast = '0;
        settle();
        chk("same_pre_outstanding", 32'(outstanding), 2);
        s_awvalid = 2'b01;
        tick();
        m_bvalid = 1'b1; s_bready = 2'b11;
        settle();
        chk("same_m_awvalid", 32'(m_awvalid), 1);
        chk("same_m_bready", 32'(m_bready), 1);
        chk("same_b_sel", 32'(b_sel), 0);
        w_exp.push_back(0);
        tick();
        s_awvalid = '0; m_bvalid = 1'b0; s_bready = '0;
        settle();
        chk("same_post_outstanding", 32'(outstanding), 2);
        chk("same_post_w_sel", 32'(w_sel), 0);
        s_wvalid = 2'b01; s_wlast = 2'b01; b_exp.push_back(0);
        tick();
        s_wvalid = '0; s_wlast = '0;
        m_bvalid = 1'b1; s_bready = 2'b11;
        settle();
        chk("same_drain_b_sel0", 32'(b_sel), 1);
        tick();
        settle();
        chk("same_drain_b_sel1", 32'(b_sel), 0);
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        settle();
        chk("same_end_outstanding", 32'(outstanding), 0);
        chk("w_queue_drained", 32'(w_exp.size()), 0);
        chk("b_queue_drained", 32'(b_exp.size()), 0);

        // Watchdog: 2^10-1 cycles with one write outstanding and no B
        s_awvalid = 2'b10;
        tick();
        settle();
        chk("tmo_m_awvalid", 32'(m_awvalid), 1);
        w_exp.push_back(1);
        tick();
        s_awvalid = '0;
        s_wvalid = 2'b10; s_wlast = 2'b10; b_exp.push_back(1);
        tick();
        s_wvalid = '0; s_wlast = '0;
        for (int i = 0; i < 1021; i++) tick();
        chk("tmo_before", 32'(dbg_b_tmo), 0);
        tick();
        chk("tmo_expired", 32'(dbg_b_tmo), 1);
        chk("tmo_outstanding", 32'(outstanding), 1);
        m_bvalid = 1'b1; s_bready = 2'b10;
        tick();
        m_bvalid = 1'b0; s_bready = '0;
        settle();
        chk("tmo_cleared", 32'(dbg_b_tmo), 0);
        chk("tmo_end_outstanding", 32'(outstanding), 0);

        // Reset in the middle of a W burst abandons the tracked write
        s_awvalid = 2'b01;
        w_exp.push_back(0);
        tick();
        tick();
        s_awvalid = '0;
        s_wvalid = 2'b01; s_wlast = 2'b00;
        tick();
        settle();
        chk("midrst_outstanding", 32'(outstanding), 1);
        chk("midrst_m_wvalid", 32'(m_wvalid), 1);
        do_reset();
        chk_quiet("midrst");
        idle_in();
        tick();
        chk_quiet("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
